// File: rtl/fft_lane_feeder_if.sv
// Stream-in and 4-lane ap_fifo-out signal bundle for fft_lane_feeder.
// master = upstream source plus FFT core; slave = the feeder itself.
interface fft_lane_feeder_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  logic [DATA_W-1:0] p_inData_dout [4];
  logic [3:0]        p_inData_empty_n;
  logic [3:0]        p_inData_read;

  modport master (
    output s_data, s_valid, s_last, p_inData_read,
    input  s_ready, p_inData_dout, p_inData_empty_n
  );

  modport slave (
    input  s_data, s_valid, s_last, p_inData_read,
    output s_ready, p_inData_dout, p_inData_empty_n
  );
endinterface

// File: rtl/fft_lane_feeder.sv
// Deals a serial sample stream round-robin into four FWFT lane FIFOs feeding
// the FFT core's ap_fifo inputs, with frame counting and sticky error flags.
module fft_lane_feeder #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  fft_lane_feeder_if.slave    bus,
  output logic [15:0]         frame_cnt,
  output logic [3:0]          underflow,
  output logic                frame_err,
  input  logic                clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(FRAME_LEN);

  logic [DATA_W-1:0] mem [4][DEPTH];
  logic [AW-1:0]     wr_ptr [4];
  logic [AW-1:0]     rd_ptr [4];
  logic [AW:0]       count  [4];
  logic [1:0]        lane_sel;
  logic [IW-1:0]     idx;

  logic [3:0] full, nonempty, push, pop, uf_evt;
  logic       accept, last_idx, frame_end, len_err;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    full     = '0;
    nonempty = '0;
    push     = '0;
    pop      = '0;
    uf_evt   = '0;
    for (int n = 0; n < 4; n++) begin
      full[n]     = (count[n] == (AW+1)'(DEPTH));
      nonempty[n] = (count[n] != '0);
    end
    // Ready looks only at registered occupancy, never at this cycle's reads.
    bus.s_ready = rst_n && !full[lane_sel];
    accept      = bus.s_valid && bus.s_ready;
    last_idx    = (idx == IW'(FRAME_LEN - 1));
    frame_end   = accept && (bus.s_last || last_idx);
    len_err     = accept && (bus.s_last != last_idx);
    for (int n = 0; n < 4; n++) begin
      push[n]   = accept && (lane_sel == 2'(n));
      pop[n]    = bus.p_inData_read[n] && nonempty[n];
      uf_evt[n] = bus.p_inData_read[n] && !nonempty[n];
      bus.p_inData_empty_n[n] = rst_n && nonempty[n];
      bus.p_inData_dout[n]    = rst_n ? mem[n][rd_ptr[n]] : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_sel  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      underflow <= '0;
      frame_err <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
      end
    end else begin
      if (accept) begin
        if (frame_end) begin
          lane_sel  <= '0;
          idx       <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          lane_sel <= lane_sel + 2'd1;
          idx      <= idx + 1'b1;
        end
      end
      for (int n = 0; n < 4; n++) begin
        if (push[n]) wr_ptr[n] <= wr_ptr[n] + 1'b1;
        if (pop[n])  rd_ptr[n] <= rd_ptr[n] + 1'b1;
        case ({push[n], pop[n]})
          2'b10:   count[n] <= count[n] + 1'b1;
          2'b01:   count[n] <= count[n] - 1'b1;
          default: count[n] <= count[n];
        endcase
        // A fresh error event wins over a simultaneous clear.
        if (uf_evt[n])    underflow[n] <= 1'b1;
        else if (clr_err) underflow[n] <= 1'b0;
      end
      if (len_err)      frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  // NOTE: lane storage is deliberately not reset; empty_n and dout gating hide stale words.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (push[n]) mem[n][wr_ptr[n]] <= bus.s_data;
    end
  end
endmodule
